// File: rtl/fpga_clk_div_cfg.sv
// Per-channel clock configuration: four-phase req/ack register port, lock
// qualification against the MMCM lock, and an integer clock-enable divider.
module fpga_clk_div_cfg #(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned DIV_WIDTH    = 8,
    parameter int unsigned LOCK_CYCLES  = 16,
    parameter int unsigned DEFAULT_DIV  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         pll_locked_i,
    input  logic [NUM_CHANNELS-1:0]      cfg_req_i,
    input  logic [NUM_CHANNELS-1:0]      cfg_wrn_i,
    input  logic [NUM_CHANNELS*2-1:0]    cfg_add_i,
    input  logic [NUM_CHANNELS*32-1:0]   cfg_data_i,
    output logic [NUM_CHANNELS-1:0]      cfg_ack_o,
    output logic [NUM_CHANNELS*32-1:0]   cfg_r_data_o,
    output logic [NUM_CHANNELS-1:0]      cfg_lock_o,
    output logic [NUM_CHANNELS-1:0]      clk_en_o
);

    localparam int unsigned LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_REL = 2'd2
    } hs_state_t;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        hs_state_t            state;
        logic                 req;
        logic                 wrn;
        logic [1:0]           add;
        logic [31:0]          wdata;
        logic                 unused_wdata;
        logic [31:0]          rd_mux;
        logic                 ack_q;
        logic [31:0]          rdata_q;
        logic [DIV_WIDTH-1:0] div_q;
        logic                 en_q;
        logic                 div_wr_q;
        logic                 relock;
        logic [LCW-1:0]       lcnt_q;
        logic [LCW-1:0]       lcnt_d;
        logic                 lock_q;
        logic [DIV_WIDTH-1:0] dcnt_q;
        logic [DIV_WIDTH-1:0] dlim;

        assign req          = cfg_req_i[g];
        assign wrn          = cfg_wrn_i[g];
        assign add          = cfg_add_i[g*2 +: 2];
        assign wdata        = cfg_data_i[g*32 +: 32];
        assign unused_wdata = ^wdata;

        always_comb begin
            rd_mux = '0;
            case (add)
                2'd0:    rd_mux[DIV_WIDTH-1:0] = div_q;
                2'd1:    rd_mux[0] = en_q;
                2'd2:    rd_mux[1:0] = {pll_locked_i, lock_q};
                default: rd_mux = 32'hdeadda7a;
            endcase
        end

        // A DIV write clears qualification one cycle after it lands, so lock
        // is still reported during the ack cycle and drops right after it.
        assign relock = ~pll_locked_i | ((state == ACK) & div_wr_q);

        always_comb begin
            lcnt_d = lcnt_q;
            if (relock)
                lcnt_d = '0;
            else if (lcnt_q != LCW'(LOCK_CYCLES))
                lcnt_d = lcnt_q + LCW'(1);
        end

        assign dlim = (div_q == '0) ? '0 : div_q - DIV_WIDTH'(1);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state    <= IDLE;
                ack_q    <= 1'b0;
                rdata_q  <= '0;
                div_q    <= DIV_WIDTH'(DEFAULT_DIV);
                en_q     <= 1'b1;
                div_wr_q <= 1'b0;
                lcnt_q   <= '0;
                lock_q   <= 1'b0;
                dcnt_q   <= '0;
            end else begin
                ack_q  <= 1'b0;
                lcnt_q <= lcnt_d;
                lock_q <= (lcnt_d == LCW'(LOCK_CYCLES));
                if (lock_q && en_q)
                    dcnt_q <= (dcnt_q == dlim) ? '0 : dcnt_q + DIV_WIDTH'(1);
                else
                    dcnt_q <= '0;

                case (state)
                    IDLE: begin
                        if (req) begin
                            state    <= ACK;
                            ack_q    <= 1'b1;
                            rdata_q  <= rd_mux;
                            div_wr_q <= ~wrn & (add == 2'd0);
                            if (!wrn) begin
                                case (add)
                                    2'd0: div_q <= wdata[DIV_WIDTH-1:0];
                                    2'd1: begin
                                        en_q   <= wdata[0];
                                        dcnt_q <= '0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                    ACK: begin
                        state    <= WAIT_REL;
                        div_wr_q <= 1'b0;
                    end
                    WAIT_REL: begin
                        if (!req)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign cfg_ack_o[g]             = ack_q;
        assign cfg_r_data_o[g*32 +: 32] = rdata_q;
        assign cfg_lock_o[g]            = lock_q;
        assign clk_en_o[g]              = lock_q & en_q & (dcnt_q == dlim);
    end

endmodule

// File: doc/fpga_clk_div_cfg.md
# fpga_clk_div_cfg

Parametrised FPGA clock-configuration block that replaces the always-acknowledge stub on the FPGA target. It serves NUM_CHANNELS independent config ports (SoC, peripheral, cluster, ...) with a real four-phase req/ack handshake and a small register file per channel. It generates per-channel clock-enable pulses by integer division of the MMCM output clock, and produces a per-channel lock that drops and re-qualifies whenever the divider changes or the MMCM loses lock. The outputs drive BUFGCE enables and the `*_cfg_lock_o` / `*_cfg_ack_o` / `*_cfg_r_data_o` nets of the SoC.

## Interface
- NUM_CHANNELS, 3: number of independent config/clock channels (≥1).
- DIV_WIDTH, 8: divider register width (1..32).
- LOCK_CYCLES, 16: qualification cycles before lock asserts (≥1).
- DEFAULT_DIV, 1: divider value loaded at reset on every channel.

Ports:
- clk_i  in  1  MMCM output clock. Single clock domain for the whole block.
- rst_i  in  1  reset, asynchronous, active-high.
- pll_locked_i  in  1  MMCM locked indication, synchronous to clk_i.
- cfg_req_i  in  NUM_CHANNELS  per-channel request.
- cfg_wrn_i  in  NUM_CHANNELS  0 = write, 1 = read.
- cfg_add_i  in  NUM_CHANNELS×2  register address.
- cfg_data_i  in  NUM_CHANNELS×32  write data.
- cfg_ack_o  out  NUM_CHANNELS  per-channel acknowledge.
- cfg_r_data_o  out  NUM_CHANNELS×32  read data; valid while ack is high.
- cfg_lock_o  out  NUM_CHANNELS  channel clock qualified.
- clk_en_o  out  NUM_CHANNELS  divided clock-enable pulse.

## Operation
- Register map per channel:
  - addr 0 DIV (RW): bits [DIV_WIDTH-1:0]; upper write bits are ignored. Values 0 and 1 both mean divide-by-1.
  - addr 1 CTRL (RW): bit0 EN, reset value 1; other bits read 0.
  - addr 2 STATUS (RO): bit0 = cfg_lock_o, bit1 = pll_locked_i, others 0.
  - addr 3 reads 32'hdeadda7a.
  - Writes to addr 2 and addr 3 are acknowledged and discarded.
- Handshake FSM per channel, with states IDLE, ACK and WAIT_REL:
  - IDLE: when req=1, perform the access, register the read data, and go to ACK.
  - ACK: ack=1 for exactly one cycle, then go to WAIT_REL.
  - WAIT_REL: hold until req=0, then go to IDLE.
  - A req held high across completion therefore produces one access only.
- Lock qualification per channel uses a counter 0..LOCK_CYCLES.
  - The counter clears when pll_locked_i=0 or when DIV is written. A DIV write always relocks, even if the value is unchanged.
  - Otherwise the counter increments and saturates at LOCK_CYCLES.
  - cfg_lock_o = (counter == LOCK_CYCLES), registered.
- Divider per channel uses a counter of DIV_WIDTH bits.
  - The counter runs only while lock=1 and EN=1; otherwise it is held at 0.
  - clk_en_o=1 when counter == D-1 (D = max(DIV,1)); counter then wraps to 0.
  - When lock=0 or EN=0, clk_en_o=0.
- Writing EN=0 stops pulses but does not drop lock. Writing EN=1 restarts the phase from counter 0.
- Channels are fully independent. Simultaneous requests on different channels are all served in parallel.

## Timing
- Reset values:
  - cfg_ack_o=0, cfg_r_data_o=0, cfg_lock_o=0, clk_en_o=0.
  - DIV=DEFAULT_DIV, EN=1, FSM=IDLE, all counters 0.
- Access latency: req sampled high at cycle t gives ack=1 and valid r_data at t+1.
  - A write takes effect at t+1, so reads issued from t+1 onward return the new value.
  - Minimum request spacing is 3 cycles (req high, ack, release).
- Lock timing:
  - pll_locked_i rising at cycle t (stable after) gives cfg_lock_o=1 at t+LOCK_CYCLES.
  - pll_locked_i falling at t gives cfg_lock_o=0 at t+1, and clk_en_o is suppressed from t+1.
- DIV write acknowledged at t: cfg_lock_o=0 from t+1 and returns at t+1+LOCK_CYCLES (given pll_locked_i=1).
- Divider timing with lock rising at cycle L: first clk_en_o pulse at L+D-1, then one pulse every D cycles. D=1 gives clk_en_o constantly high.
- A DIV write in the same cycle as a pll_locked_i drop: both clear the lock counter, and qualification restarts when pll_locked_i returns.
- Reset asserted mid-handshake: FSM returns to IDLE and ack drops immediately. The master must re-issue the request.

## Test plan
- Reset release with pll_locked_i=1 from cycle 0, LOCK_CYCLES=16, DEFAULT_DIV=1 -> cfg_lock_o=1 at cycle 16 on all channels; clk_en_o high every cycle from cycle 16.
- Channel 0 write DIV=4 (wrn=0, add=0, data=32'h104) -> ack one cycle later; lock low for 16 cycles; then clk_en_o pulses at L+3, L+7, L+11; read addr0 returns 32'h4.
- Read addr3 and addr2 on channel 1 while locked -> r_data 32'hdeadda7a, then 32'h3. Write addr2 -> ack, STATUS unchanged.
- pll_locked_i low for 5 cycles with DIV=3 -> all cfg_lock_o and clk_en_o drop the next cycle; lock returns 16 cycles after pll_locked_i re-rises.
- req held high for 10 cycles on channel 2 (write CTRL=0) -> exactly one ack pulse; clk_en_o stops while cfg_lock_o stays 1. Then write CTRL=1 -> first pulse D-1 cycles after the write takes effect.
- Simultaneous writes on all channels (DIV=2,5,0), plus rst_i asserted in the ACK cycle of a fourth request -> ack drops immediately and all registers return to reset values.
